// File: rtl/speed_meas_pkg.sv
// Shared constants and types for the encoder pulse-timing speed measurement path.
package speed_meas_pkg;

    localparam int unsigned DATA_W = 26;
    localparam int unsigned MODE_W = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned WD_W   = 16;

    localparam logic [IDX_W-1:0]  IDX_MAX       = IDX_W'(4);
    localparam logic [DATA_W-1:0] TIME_MAX      = DATA_W'(67108863);
    localparam logic [DATA_W-1:0] SPEED_SAT     = DATA_W'(26'h3FFFFFF);
    localparam logic [DATA_W-1:0] DIVIDEND_BASE = DATA_W'(390625);

    // Pulses per measurement, indexed by mode index 0..4
    localparam logic [4:0][MODE_W-1:0] MODE_TABLE = {8'd128, 8'd64, 8'd16, 8'd4, 8'd1};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIV_REQ,
        ST_DIV_WAIT,
        ST_OUTPUT,
        ST_UPDATE
    } state_t;

    typedef enum logic [1:0] {
        VOTE_NONE,
        VOTE_UP,
        VOTE_DOWN
    } vote_t;

    typedef struct packed {
        logic [DATA_W-1:0] dividend;
        logic [DATA_W-1:0] divisor;
    } div_req_t;

    function automatic logic [MODE_W-1:0] mode_value_of(input logic [IDX_W-1:0] idx);
        logic [MODE_W-1:0] val;
        case (idx)
            3'd0:    val = MODE_TABLE[0];
            3'd1:    val = MODE_TABLE[1];
            3'd2:    val = MODE_TABLE[2];
            3'd3:    val = MODE_TABLE[3];
            default: val = MODE_TABLE[4];
        endcase
        return val;
    endfunction

endpackage

// File: rtl/speed_mode_hysteresis.sv
// Mode index with vote hysteresis: a mode step needs HYST_CNT consecutive same-direction votes.
module speed_mode_hysteresis
    import speed_meas_pkg::*;
#(
    parameter int unsigned HYST_CNT = 2
) (
    input  logic              sys_clk,
    input  logic              reset_n,
    input  logic              update_en,
    input  logic              force_zero,
    input  vote_t             vote,
    output logic [IDX_W-1:0]  mode_idx,
    output logic [MODE_W-1:0] mode_value,
    output logic              mode_strobe
);

    localparam int unsigned CNT_W = $clog2(HYST_CNT + 1);

    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [CNT_W-1:0]  cnt_step;
    vote_t             dir_q;
    vote_t             dir_d;
    logic [IDX_W-1:0]  idx_d;
    logic              strobe_d;

    always_comb begin
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        idx_d    = mode_idx;
        strobe_d = 1'b0;
        cnt_step = '0;
        if (update_en) begin
            if (force_zero) begin
                cnt_d    = '0;
                dir_d    = VOTE_NONE;
                idx_d    = '0;
                strobe_d = (mode_idx != '0);
            end else if (vote == VOTE_NONE) begin
                cnt_d = '0;
                dir_d = VOTE_NONE;
            end else begin
                // Opposite direction restarts the run at one vote
                cnt_step = (vote == dir_q) ? cnt_q + CNT_W'(1) : CNT_W'(1);
                dir_d    = vote;
                if (cnt_step == CNT_W'(HYST_CNT)) begin
                    cnt_d    = '0;
                    idx_d    = (vote == VOTE_UP) ? mode_idx + IDX_W'(1) : mode_idx - IDX_W'(1);
                    strobe_d = 1'b1;
                end else begin
                    cnt_d = cnt_step;
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            dir_q       <= VOTE_NONE;
            mode_idx    <= '0;
            mode_value  <= MODE_TABLE[0];
            mode_strobe <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            mode_idx    <= idx_d;
            mode_value  <= mode_value_of(idx_d);
            mode_strobe <= strobe_d;
        end
    end

endmodule

// File: rtl/speed_mode_divider_scheduler.sv
// Sequences the shared serial divider for each pulse-timing result and
// selects the next speed-area mode for the pulse-timing counter.
module speed_mode_divider_scheduler
    import speed_meas_pkg::*;
#(
    parameter logic [DATA_W-1:0] SHORT_THR   = 26'd50000,
    parameter logic [DATA_W-1:0] LONG_THR    = 26'd2000000,
    parameter int unsigned       HYST_CNT    = 2,
    parameter logic [WD_W-1:0]   DIV_TIMEOUT = 16'd64
) (
    input  logic              sys_clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] speed_pluse_time_cnt_in,
    input  logic [DATA_W-1:0] speed_pluse_count_dividend_in,
    input  logic              speed_cnt_valid_in,
    output logic [MODE_W-1:0] speed_area_count_value_out,
    output logic              speed_area_count_valid_out,
    output logic              div_start_out,
    output logic [DATA_W-1:0] div_dividend_out,
    output logic [DATA_W-1:0] div_divisor_out,
    input  logic              div_done_in,
    input  logic [DATA_W-1:0] div_quotient_in,
    output logic [DATA_W-1:0] speed_value_out,
    output logic              speed_valid_out,
    output logic              overrun_out,
    output logic              div_err_out
);

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] time_q;
    logic [DATA_W-1:0] time_d;
    logic              time_max_q;
    logic              time_max_d;
    logic              timed_out_q;
    logic              timed_out_d;
    logic [WD_W-1:0]   wd_q;
    logic [WD_W-1:0]   wd_d;
    div_req_t          div_req_q;
    div_req_t          div_req_d;
    logic              div_start_d;
    logic [DATA_W-1:0] speed_value_d;
    logic              speed_valid_d;
    logic              overrun_d;
    logic              div_err_d;
    logic              update_en_c;
    vote_t             vote_c;
    logic [IDX_W-1:0]  mode_idx;

    assign div_dividend_out = div_req_q.dividend;
    assign div_divisor_out  = div_req_q.divisor;

    // Vote from the latched time count against the current mode index
    always_comb begin
        vote_c = VOTE_NONE;
        if ((time_q < SHORT_THR) && (mode_idx < IDX_MAX)) begin
            vote_c = VOTE_UP;
        end else if ((time_q > LONG_THR) && (mode_idx != '0)) begin
            vote_c = VOTE_DOWN;
        end
    end

    always_comb begin
        state_d       = state_q;
        time_d        = time_q;
        time_max_d    = time_max_q;
        timed_out_d   = timed_out_q;
        wd_d          = wd_q;
        div_req_d     = div_req_q;
        div_start_d   = 1'b0;
        speed_value_d = speed_value_out;
        speed_valid_d = 1'b0;
        div_err_d     = 1'b0;
        update_en_c   = 1'b0;
        overrun_d     = speed_cnt_valid_in && (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (speed_cnt_valid_in) begin
                    time_d      = speed_pluse_time_cnt_in;
                    time_max_d  = (speed_pluse_time_cnt_in == TIME_MAX);
                    timed_out_d = 1'b0;
                    if (speed_pluse_time_cnt_in == TIME_MAX) begin
                        speed_value_d = '0;
                        state_d       = ST_OUTPUT;
                    end else if (speed_pluse_time_cnt_in == '0) begin
                        speed_value_d = SPEED_SAT;
                        state_d       = ST_OUTPUT;
                    end else begin
                        div_req_d.dividend = speed_pluse_count_dividend_in;
                        div_req_d.divisor  = speed_pluse_time_cnt_in;
                        div_start_d        = 1'b1;
                        state_d            = ST_DIV_REQ;
                    end
                end
            end
            ST_DIV_REQ: begin
                wd_d    = '0;
                state_d = ST_DIV_WAIT;
            end
            ST_DIV_WAIT: begin
                if (div_done_in) begin
                    speed_value_d = div_quotient_in;
                    state_d       = ST_OUTPUT;
                end else if (wd_q == DIV_TIMEOUT - WD_W'(1)) begin
                    div_err_d   = 1'b1;
                    timed_out_d = 1'b1;
                    state_d     = ST_UPDATE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_OUTPUT: begin
                speed_valid_d = 1'b1;
                state_d       = ST_UPDATE;
            end
            ST_UPDATE: begin
                // A timed-out division carries no speed, so it casts no vote
                update_en_c = !timed_out_q;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            time_q          <= '0;
            time_max_q      <= 1'b0;
            timed_out_q     <= 1'b0;
            wd_q            <= '0;
            div_req_q       <= '0;
            div_start_out   <= 1'b0;
            speed_value_out <= '0;
            speed_valid_out <= 1'b0;
            overrun_out     <= 1'b0;
            div_err_out     <= 1'b0;
        end else begin
            state_q         <= state_d;
            time_q          <= time_d;
            time_max_q      <= time_max_d;
            timed_out_q     <= timed_out_d;
            wd_q            <= wd_d;
            div_req_q       <= div_req_d;
            div_start_out   <= div_start_d;
            speed_value_out <= speed_value_d;
            speed_valid_out <= speed_valid_d;
            overrun_out     <= overrun_d;
            div_err_out     <= div_err_d;
        end
    end

    speed_mode_hysteresis #(
        .HYST_CNT (HYST_CNT)
    ) u_hyst (
        .sys_clk     (sys_clk),
        .reset_n     (reset_n),
        .update_en   (update_en_c),
        .force_zero  (time_max_q),
        .vote        (vote_c),
        .mode_idx    (mode_idx),
        .mode_value  (speed_area_count_value_out),
        .mode_strobe (speed_area_count_valid_out)
    );

endmodule
